sram_port_arbiter: RTL

// Shares the single SRAM controller port between NUM_REQ requesters (UART loader, M1, M2, M3 engines).

---
 rtl/sram_port_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares the single SRAM_Controller port between NUM_REQ requester engines
//   (UART loader, M1, M2, M3) using round-robin request/grant handshakes.
//   An owner keeps the port while it holds req. With MAX_BURST != 0 it is
//   preempted after MAX_BURST consecutive cycles if someone else is waiting.
//   Read data is routed back to the requester that issued the read. A tag
//   travels alongside the READ_LAT-cycle SRAM read latency for this purpose.
// Ports
//   CLOCK_50_I      single 50 MHz clock
//   resetn          synchronous active-low reset
//   req             per-requester level request
//   req_address     packed, requester i at [i*ADDR_W +: ADDR_W]
//   req_write_data  packed, requester i at [i*DATA_W +: DATA_W]
//   req_we_n        per-requester write enable, active low
//   grant           registered one-hot (or zero) ownership
//   SRAM_address / SRAM_write_data / SRAM_we_n   to SRAM_Controller
//   SRAM_read_data  from SRAM_Controller
//   rd_data         SRAM_read_data passed through
//   rd_valid        rd_data belongs to requester i this cycle
//   busy            any grant active

// Per-requester slice: masks the requester's bus with its grant and decodes
// whether the read tag at the pipeline tail belongs to it.
module sram_port_arbiter_lane #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 2,
  parameter int LANE   = 0
) (
  input  logic              gnt,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we_n,
  input  logic              tail_vld,
  input  logic [IDX_W-1:0]  tail_idx,
  output logic [ADDR_W-1:0] addr_m,
  output logic [DATA_W-1:0] wdata_m,
  output logic              wr_m,
  output logic              rd_m,
  output logic              rd_valid
);
  assign addr_m   = gnt ? addr  : '0;
  assign wdata_m  = gnt ? wdata : '0;
  assign wr_m     = gnt & ~we_n;
  assign rd_m     = gnt &  we_n;
  assign rd_valid = tail_vld && (tail_idx == IDX_W'(LANE));
endmodule

module sram_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int READ_LAT  = 2,
  parameter int MAX_BURST = 1024
) (
  input  logic                      CLOCK_50_I,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*DATA_W-1:0] req_write_data,
  input  logic [NUM_REQ-1:0]        req_we_n,
  output logic [NUM_REQ-1:0]        grant,
  output logic [ADDR_W-1:0]         SRAM_address,
  output logic [DATA_W-1:0]         SRAM_write_data,
  output logic                      SRAM_we_n,
  input  logic [DATA_W-1:0]         SRAM_read_data,
  output logic [DATA_W-1:0]         rd_data,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic                      busy
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  // Counter saturates here; with MAX_BURST=0 it simply stays at 0.
  localparam logic [CNT_W-1:0] CNT_MAX = (MAX_BURST == 0) ? '0 : CNT_W'(MAX_BURST - 1);

  typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;

  arb_state_t                       state, state_nxt;
  logic [NUM_REQ-1:0]               grant_nxt;
  logic [IDX_W-1:0]                 rr_ptr, rr_ptr_nxt, owner, cand;
  logic [CNT_W-1:0]                 burst_cnt, burst_cnt_nxt;
  logic [IDX_W:0]                   sum;
  logic                             found, preempt, others_pending, rd_issue;

  logic [NUM_REQ-1:0][ADDR_W-1:0]   addr_m;
  logic [NUM_REQ-1:0][DATA_W-1:0]   wdata_m;
  logic [NUM_REQ-1:0]               wr_m, rd_m;

  // Read-tag pipeline: stage 1 is the cycle after issue, stage READ_LAT the tail.
  logic [READ_LAT:1]                vld_pipe;
  logic [READ_LAT:1][IDX_W-1:0]     idx_pipe;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    sram_port_arbiter_lane #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W), .LANE(i)
    ) u_lane (
      .gnt      (grant[i]),
      .addr     (req_address[i*ADDR_W +: ADDR_W]),
      .wdata    (req_write_data[i*DATA_W +: DATA_W]),
      .we_n     (req_we_n[i]),
      .tail_vld (vld_pipe[READ_LAT]),
      .tail_idx (idx_pipe[READ_LAT]),
      .addr_m   (addr_m[i]),
      .wdata_m  (wdata_m[i]),
      .wr_m     (wr_m[i]),
      .rd_m     (rd_m[i]),
      .rd_valid (rd_valid[i])
    );
  end

  // Grant is one-hot, so OR-ing the masked lanes is the bus mux.
  always_comb begin
    SRAM_address    = '0;
    SRAM_write_data = '0;
    owner           = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      SRAM_address    = SRAM_address | addr_m[i];
      SRAM_write_data = SRAM_write_data | wdata_m[i];
      if (grant[i]) owner = IDX_W'(i);
    end
  end

  // Reset gates the write strobe immediately, even mid-write.
  assign SRAM_we_n      = ~(resetn & (|wr_m));
  assign rd_issue       = |rd_m;
  assign busy           = |grant;
  assign rd_data        = SRAM_read_data;
  assign others_pending = |(req & ~grant);

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    found         = 1'b0;
    preempt       = 1'b0;
    sum           = '0;
    cand          = '0;
    case (state)
      ARB_IDLE: begin
        // Scan rr_ptr+1, rr_ptr+2, ... wrapping at NUM_REQ; first set bit wins.
        for (int k = 1; k <= NUM_REQ; k++) begin
          sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
          if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
          cand = sum[IDX_W-1:0];
          if (!found && req[cand]) begin
            found           = 1'b1;
            grant_nxt       = '0;
            grant_nxt[cand] = 1'b1;
          end
        end
        if (found) begin
          state_nxt     = ARB_OWN;
          burst_cnt_nxt = '0;
        end
      end
      ARB_OWN: begin
        preempt = (MAX_BURST != 0) && (burst_cnt == CNT_MAX) && others_pending;
        if (!req[owner] || preempt) begin
          grant_nxt     = '0;
          rr_ptr_nxt    = owner;
          burst_cnt_nxt = '0;
          state_nxt     = ARB_IDLE;
        end else if (burst_cnt != CNT_MAX) begin
          burst_cnt_nxt = burst_cnt + 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (!resetn) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      rr_ptr    <= IDX_W'(NUM_REQ - 1);
      burst_cnt <= '0;
      vld_pipe  <= '0;
      idx_pipe  <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      rr_ptr      <= rr_ptr_nxt;
      burst_cnt   <= burst_cnt_nxt;
      vld_pipe[1] <= rd_issue;
      idx_pipe[1] <= owner;
      for (int s = 2; s <= READ_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        idx_pipe[s] <= idx_pipe[s-1];
      end
    end
  end
endmodule
